// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    // Number of decimal digits needed to hold 2^bin_w - 1.
    function automatic int bcd_digits(input int bin_w);
        logic [63:0] v;
        int          d;
        v = (bin_w >= 64) ? {64{1'b1}} : ((64'd1 << bin_w) - 64'd1);
        d = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_conv_seq_if.sv
// Valid/ready request and result streams of the BCD converter.
interface bcd_conv_seq_if #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
);
    localparam int NDW = $clog2(DIGITS + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      in_bin;
    logic                  in_signed;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_neg;
    logic [NDW-1:0]        out_ndigits;

    // master: producer of words and consumer of results
    modport master (
        output in_valid, in_bin, in_signed, out_ready,
        input  in_ready, out_valid, out_bcd, out_neg, out_ndigits
    );

    modport slave (
        input  in_valid, in_bin, in_signed, out_ready,
        output in_ready, out_valid, out_bcd, out_neg, out_ndigits
    );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: digits of 5 or more get +3 before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_NIBBLE_W-1:0] din,
    output logic [BCD_NIBBLE_W-1:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bcd_conv_seq.sv
// Iterative binary-to-BCD converter, one bit per clock, with sign flag and
// significant-digit count for leading-zero blanking.
module bcd_conv_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W     = 32,
    parameter int DIGITS    = 10,
    parameter int SIGNED_EN = 1
) (
    input  logic           clk,
    input  logic           rst,
    bcd_conv_seq_if.slave  bus
);
    localparam int NDW = $clog2(DIGITS + 1);
    localparam int CW  = $clog2(BIN_W + 1);
    localparam int AW  = BCD_NIBBLE_W * DIGITS;

    if (BIN_W < 2 || BIN_W > 64) begin : g_bad_bin_w
        $error("bcd_conv_seq: BIN_W must be in 2..64");
    end
    if (DIGITS < bcd_digits(BIN_W)) begin : g_bad_digits
        $error("bcd_conv_seq: DIGITS too small for BIN_W");
    end

    bcd_state_t       state_reg, state_next;
    logic [BIN_W-1:0] shift_reg;
    logic [AW-1:0]    acc_reg;
    logic [AW-1:0]    bcd_reg;
    logic [CW-1:0]    cnt_reg;
    logic             neg_reg;
    logic             valid_reg;

    logic             in_ready_int;
    logic             do_shift;
    logic             last_iter;
    logic             accept;
    logic             sign_in;
    logic [BIN_W-1:0] mag_in;
    logic [AW-1:0]    acc_adj;
    logic [AW-1:0]    acc_shifted;
    logic [NDW-1:0]   ndigits_next;

    genvar gi;
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (acc_reg[gi*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
            .dout (acc_adj[gi*BCD_NIBBLE_W +: BCD_NIBBLE_W])
        );
    end

    assign acc_shifted = {acc_adj[AW-2:0], shift_reg[BIN_W-1]};

    // Most-negative input negates to itself, which reads as 2^(BIN_W-1) unsigned.
    assign sign_in = bus.in_signed && (SIGNED_EN != 0) && bus.in_bin[BIN_W-1];
    assign mag_in  = sign_in ? -bus.in_bin : bus.in_bin;
    assign accept  = bus.in_valid && in_ready_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (bus.in_valid) state_next = SHIFT;
            SHIFT:   if (cnt_reg == CW'(1)) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = bus.in_valid ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_int = 1'b0;
        do_shift     = 1'b0;
        last_iter    = 1'b0;
        unique case (state_reg)
            IDLE:  in_ready_int = 1'b1;
            SHIFT: begin
                do_shift  = 1'b1;
                last_iter = (cnt_reg == CW'(1));
            end
            DONE:  in_ready_int = bus.out_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            acc_reg   <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            neg_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                shift_reg <= mag_in;
                acc_reg   <= '0;
                neg_reg   <= sign_in;
                cnt_reg   <= CW'(BIN_W);
            end else if (do_shift) begin
                shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
                acc_reg   <= acc_shifted;
                cnt_reg   <= cnt_reg - CW'(1);
            end
            // The visible result only changes when the last iteration lands.
            if (last_iter) begin
                bcd_reg   <= acc_shifted;
                valid_reg <= 1'b1;
            end else if (state_reg == DONE && bus.out_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        ndigits_next = NDW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_reg[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] != '0) ndigits_next = NDW'(i + 1);
        end
    end

    assign bus.in_ready    = in_ready_int;
    assign bus.out_valid   = valid_reg;
    assign bus.out_bcd     = bcd_reg;
    assign bus.out_neg     = neg_reg;
    assign bus.out_ndigits = ndigits_next;

endmodule

// File: doc/bcd_conv_seq.md
Name: bcd_conv_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Optional signed mode: the sign goes to a separate flag and the magnitude is converted.
- Also reports the significant-digit count, for leading-zero blanking on the 7-segment/UART display path.
- Sits between the register-file/MMIO debug tap and the display driver, with valid/ready on both sides.

Parameters:
- BIN_W, 32, binary input width (2..64).
- DIGITS, 10, BCD digit count; must satisfy 10^DIGITS > 2^BIN_W - 1 (32->10, 16->5, 8->3). Elaboration error otherwise.
- SIGNED_EN, 1, 1 = in_signed honoured; 0 = in_signed ignored, out_neg tied 0.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_bin  in  BIN_W  binary value
- in_signed  in  1  treat in_bin as two's complement
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_bcd  out  4*DIGITS  packed BCD, digit 0 at [3:0]
- out_neg  out  1  result is negative
- out_ndigits  out  clog2(DIGITS+1)  significant digits, 1..DIGITS

Behaviour:
- States: IDLE, SHIFT, DONE. Reset values: state=IDLE, out_valid=0, out_bcd=0, out_neg=0, bit counter=0.
- out_ndigits is combinational from out_bcd, so it reads 1 in reset.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept (in_valid && in_ready):
  - Magnitude: mag = (in_signed && SIGNED_EN && in_bin[BIN_W-1]) ? -in_bin : in_bin, computed in BIN_W bits and treated as unsigned. Most-negative maps to 2^(BIN_W-1).
  - Load: shift reg = mag, BCD accumulator = 0, out_neg register = sign, counter = BIN_W.
  - Next state: SHIFT.
- SHIFT, each cycle:
  - Every accumulator digit >= 5 gets +3 (4-bit, no carry between digits). Then {acc,shift} shifts left 1 and the counter decrements.
  - The edge that performs the BIN_W-th iteration moves to DONE and sets out_valid=1.
- Latency: out_valid rises exactly BIN_W clock edges after the accept edge (32 for the default).
- DONE:
  - out_bcd, out_neg and out_ndigits are held stable until out_valid && out_ready.
  - On handshake: out_valid=0, state=IDLE, or SHIFT if a new word is accepted on the same edge. Back-to-back throughput is BIN_W+1 cycles per word.
- out_bcd is updated only on the SHIFT->DONE edge. The consumer never sees intermediate accumulator values.
- in_valid in SHIFT is ignored (in_ready=0); the word must be held by the producer.
- out_ndigits = index of the highest non-zero digit + 1. If all digits are zero it is 1.
- rst asserted mid-conversion: immediate return to IDLE with all outputs at reset values. The partial result is discarded and nothing is emitted.
- Zero input: goes through the full BIN_W iterations, with no early exit, so latency is deterministic.
- Signed input with value 0 and in_signed=1: out_neg=0 (no negative zero).
- All registers are on clk rising edge with asynchronous rst; no other clock domain.

Decomposition:
- Shared package bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - function bcd_digits(bin_w) returning the minimum digit count, used for the DIGITS default check
  - constant BCD_NIBBLE_W=4
- Sub-module bcd_add3: combinational 4-bit digit adjust, >=5 -> +3 else passthrough. Instantiated DIGITS times in a generate loop.

Test Plan:
- BIN_W=32, unsigned 32'hFFFFFFFF -> after 32 cycles:
  - out_bcd=40'h4294967295, out_neg=0, out_ndigits=10.
- Unsigned 32'd0 -> out_bcd=0, out_ndigits=1, latency still 32.
- Signed 32'h80000000 -> out_bcd=40'h2147483648, out_neg=1.
- Signed 32'hFFFFFFFF -> out_bcd=1, out_neg=1, out_ndigits=1.
- Backpressure: hold out_ready=0 for 10 cycles on 32'd1234567.
  - Outputs stay stable and in_ready=0 throughout.
  - Then out_ready=1 with a new in_valid on 32'd99 on the same cycle: 32'd99 is accepted on that edge and out_bcd=40'h99 arrives 32 cycles later.
- Reset mid-SHIFT (cycle 15 of 32'd55555) -> out_valid never rises; post-reset conversion of 32'd7 gives 40'h7.
- Instance with BIN_W=8, DIGITS=3: 8'd255 -> 12'h255 after 8 cycles.
